spi_sub_sync: RTL and testbench

- System-clocked, parametrised successor to the free-running SPI subordinate that feeds the AES core.
- Oversamples SCLK/CS_N/SDI in the `clk` domain.
- Supports all four SPI modes.
- Decodes a 2-bit key-size header (128/192/256-bit payload) and delivers the payload to AES with a valid/ready handshake.
- Shifts an AES result word back to the controller on SDO, with frame-error and overrun reporting.

---
 rtl/spi_pkg.sv | 31 +++
 rtl/spi_in_sync.sv | 33 +++
 rtl/spi_sub_sync.sv | 248 ++++++++++++++++++++++++
 tb/tb_spi_sub_sync.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared constants and FSM state type for the system-clocked SPI subordinate.
package spi_pkg;

    localparam logic [1:0] HDR_K128 = 2'b00;
    localparam logic [1:0] HDR_K192 = 2'b01;
    localparam logic [1:0] HDR_K256 = 2'b10;
    localparam logic [1:0] HDR_RSVD = 2'b11;

    localparam int LEN_K128 = 128;
    localparam int LEN_K192 = 192;
    localparam int LEN_K256 = 256;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_HOLD,
        ST_ERR
    } state_t;

    // Reserved code maps to 0; the FSM never loads it as a length.
    function automatic int hdr_len(input logic [1:0] code);
        case (code)
            HDR_K128: hdr_len = LEN_K128;
            HDR_K192: hdr_len = LEN_K192;
            HDR_K256: hdr_len = LEN_K256;
            default:  hdr_len = 0;
        endcase
    endfunction

endpackage

// File: rtl/spi_in_sync.sv
// Two-flop synchroniser with a third flop for rise/fall detection of one input.
module spi_in_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    assign o_rise = r_sync & ~r_prev;
    assign o_fall = ~r_sync & r_prev;

endmodule

// File: rtl/spi_sub_sync.sv
// Oversampled SPI subordinate: header-decoded payload receive with valid/ready
// delivery, MSB-first result transmit, sticky frame-error and overrun flags.
module spi_sub_sync
    import spi_pkg::*;
#(
    parameter int   TX_W    = 128,
    parameter int   PAY_MAX = 256,
    parameter int   HDR_W   = 2,
    parameter logic CPOL    = 1'b0,
    parameter logic CPHA    = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               sclk,
    input  logic               cs_n,
    input  logic               sdi,
    output logic               sdo,
    output logic               sdo_oe,
    input  logic [TX_W-1:0]    tx_data,
    input  logic               tx_valid,
    output logic [PAY_MAX-1:0] rx_data,
    output logic [1:0]         rx_mode,
    output logic               rx_valid,
    input  logic               rx_ready,
    output logic               frame_err,
    output logic               overrun,
    input  logic               err_clr
);

    localparam int CNT_W = $clog2(PAY_MAX + 1);
    localparam int TXC_W = $clog2(TX_W + 1);

    logic w_sclk_sync, w_sclk_rise, w_sclk_fall;
    logic w_cs, w_cs_rise, w_cs_fall;
    logic w_sdi, w_sdi_rise, w_sdi_fall;
    logic w_unused_edges;

    spi_in_sync #(.RST_VAL(CPOL)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .i_async(sclk),
        .o_sync(w_sclk_sync), .o_rise(w_sclk_rise), .o_fall(w_sclk_fall)
    );

    spi_in_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst_n(rst_n), .i_async(cs_n),
        .o_sync(w_cs), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_in_sync #(.RST_VAL(1'b0)) u_sync_sdi (
        .clk(clk), .rst_n(rst_n), .i_async(sdi),
        .o_sync(w_sdi), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );

    assign w_unused_edges = ^{w_sclk_sync, w_cs_rise, w_cs_fall, w_sdi_rise, w_sdi_fall};

    logic w_lead, w_trail, w_sample, w_shift;

    assign w_lead   = CPOL ? w_sclk_fall : w_sclk_rise;
    assign w_trail  = CPOL ? w_sclk_rise : w_sclk_fall;
    assign w_sample = CPHA ? w_trail : w_lead;
    assign w_shift  = CPHA ? w_lead : w_trail;

    state_t r_state, w_state_next;

    logic [PAY_MAX-2:0] r_rx;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_mode;
    logic [TX_W-1:0]    r_tx;
    logic [TXC_W-1:0]   r_tx_left;
    logic               r_sdo;
    logic               r_oe;
    logic [PAY_MAX-1:0] r_rx_data;
    logic [1:0]         r_rx_mode;
    logic               r_rx_valid;
    logic               r_ferr;
    logic               r_ovr;

    logic [PAY_MAX-1:0] w_rx_next;
    logic [1:0]         w_hdr_code;
    logic [CNT_W-1:0]   w_len;
    logic [TX_W-1:0]    w_tx_load;
    logic               w_accept;

    assign w_rx_next  = {r_rx, w_sdi};
    assign w_hdr_code = w_rx_next[1:0];
    assign w_len      = CNT_W'(hdr_len(w_hdr_code));
    assign w_tx_load  = tx_valid ? tx_data : '0;
    assign w_accept   = r_rx_valid & rx_ready;

    logic w_start, w_drive, w_hdr_smp, w_hdr_done, w_pay_smp;
    logic w_deliver, w_ovr_set, w_ferr_set, w_quiet, w_frame_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_start      = 1'b0;
        w_drive      = 1'b0;
        w_hdr_smp    = 1'b0;
        w_hdr_done   = 1'b0;
        w_pay_smp    = 1'b0;
        w_deliver    = 1'b0;
        w_ovr_set    = 1'b0;
        w_ferr_set   = 1'b0;
        w_quiet      = 1'b0;
        w_frame_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs) begin
                    w_start      = 1'b1;
                    w_state_next = ST_HDR;
                end
            end
            ST_HDR: begin
                if (w_cs) begin
                    w_ferr_set   = 1'b1;
                    w_frame_end  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_drive = w_shift;
                    if (w_sample) begin
                        w_hdr_smp = 1'b1;
                        if (r_cnt == CNT_W'(HDR_W - 1)) begin
                            if (w_hdr_code == HDR_RSVD) begin
                                w_ferr_set   = 1'b1;
                                w_quiet      = 1'b1;
                                w_state_next = ST_ERR;
                            end else begin
                                w_hdr_done   = 1'b1;
                                w_state_next = ST_PAY;
                            end
                        end
                    end
                end
            end
            ST_PAY: begin
                if (w_cs) begin
                    w_ferr_set   = 1'b1;
                    w_frame_end  = 1'b1;
                    w_state_next = ST_IDLE;
                end else begin
                    w_drive = w_shift;
                    if (w_sample) begin
                        w_pay_smp = 1'b1;
                        if (r_cnt == CNT_W'(1)) begin
                            // A same-cycle accept frees the slot, so no overrun.
                            if (!r_rx_valid || w_accept) w_deliver = 1'b1;
                            else                         w_ovr_set = 1'b1;
                            w_quiet      = 1'b1;
                            w_state_next = ST_HOLD;
                        end
                    end
                end
            end
            ST_HOLD, ST_ERR: begin
                if (w_cs) begin
                    w_frame_end  = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx       <= '0;
            r_cnt      <= '0;
            r_mode     <= '0;
            r_tx       <= '0;
            r_tx_left  <= '0;
            r_sdo      <= 1'b0;
            r_oe       <= 1'b0;
            r_rx_data  <= '0;
            r_rx_mode  <= '0;
            r_rx_valid <= 1'b0;
            r_ferr     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
                r_oe  <= 1'b1;
                r_rx  <= '0;
                // Leading-edge sampling needs the MSB on the wire before any SCLK edge.
                if (CPHA) begin
                    r_tx      <= w_tx_load;
                    r_tx_left <= TXC_W'(TX_W);
                    r_sdo     <= 1'b0;
                end else begin
                    r_tx      <= {w_tx_load[TX_W-2:0], 1'b0};
                    r_tx_left <= TXC_W'(TX_W - 1);
                    r_sdo     <= w_tx_load[TX_W-1];
                end
            end
            if (w_drive) begin
                if (r_tx_left != '0) begin
                    r_sdo     <= r_tx[TX_W-1];
                    r_tx      <= {r_tx[TX_W-2:0], 1'b0};
                    r_tx_left <= r_tx_left - 1'b1;
                end else begin
                    r_sdo <= 1'b0;
                end
            end
            if (w_hdr_smp) begin
                if (w_hdr_done) begin
                    r_rx   <= '0;
                    r_cnt  <= w_len;
                    r_mode <= w_hdr_code;
                end else begin
                    r_rx  <= w_rx_next[PAY_MAX-2:0];
                    r_cnt <= r_cnt + 1'b1;
                end
            end
            if (w_pay_smp) begin
                r_rx  <= w_rx_next[PAY_MAX-2:0];
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_quiet) r_sdo <= 1'b0;
            if (w_frame_end) begin
                r_oe  <= 1'b0;
                r_sdo <= 1'b0;
                r_cnt <= '0;
            end
            if (w_deliver) begin
                r_rx_data  <= w_rx_next;
                r_rx_mode  <= r_mode;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
            if (w_ferr_set)   r_ferr <= 1'b1;
            else if (err_clr) r_ferr <= 1'b0;
            if (w_ovr_set)    r_ovr  <= 1'b1;
            else if (err_clr) r_ovr  <= 1'b0;
        end
    end

    assign sdo       = r_sdo;
    assign sdo_oe    = r_oe;
    assign rx_data   = r_rx_data;
    assign rx_mode   = r_rx_mode;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_spi_sub_sync.sv
// Directed bench for spi_sub_sync: mode 1 main instance plus modes 0, 2, 3
// sharing the same bit stream (CPOL=1 parts see the inverted SCLK).
module tb_spi_sub_sync;

    localparam int Q = 3;

    logic         clk;
    logic         rst_n;
    logic         sclk0;
    logic         sclk1;
    logic         cs_n;
    logic         sdi;
    logic [127:0] tx_data;
    logic         tx_valid;
    logic         rx_ready;
    logic         err_clr;

    logic         sdo, sdo_oe, rx_valid, frame_err, overrun;
    logic [255:0] rx_data;
    logic [1:0]   rx_mode;

    logic         sdo_m0, oe_m0, vld_m0, ferr_m0, ovr_m0;
    logic         sdo_m2, oe_m2, vld_m2, ferr_m2, ovr_m2;
    logic         sdo_m3, oe_m3, vld_m3, ferr_m3, ovr_m3;
    logic [255:0] rxd_m0, rxd_m2, rxd_m3;
    logic [1:0]   mode_m0, mode_m2, mode_m3;

    int checks;
    int errors;

    logic [299:0] cap1;
    logic [299:0] cap0;
    logic         vld_before_last;
    logic [127:0] got;
    logic [255:0] held;

    localparam logic [127:0] P128 = 128'h0123456789ABCDEF0123456789ABCDEF;
    localparam logic [191:0] P192 = {3{64'h0123456789ABCDEF}};
    localparam logic [127:0] PDEAD = {4{32'hDEADBEEF}};
    localparam logic [127:0] TXA5 = {16{8'hA5}};
    localparam logic [127:0] TXC3 = {16{8'hC3}};

    assign sclk1 = ~sclk0;

    spi_sub_sync u_dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .tx_data(tx_data), .tx_valid(tx_valid),
        .rx_data(rx_data), .rx_mode(rx_mode), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .frame_err(frame_err), .overrun(overrun), .err_clr(err_clr)
    );

    spi_sub_sync #(.CPOL(1'b0), .CPHA(1'b0)) u_m0 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk0), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_m0), .sdo_oe(oe_m0), .tx_data(tx_data), .tx_valid(tx_valid),
        .rx_data(rxd_m0), .rx_mode(mode_m0), .rx_valid(vld_m0), .rx_ready(rx_ready),
        .frame_err(ferr_m0), .overrun(ovr_m0), .err_clr(err_clr)
    );

    spi_sub_sync #(.CPOL(1'b1), .CPHA(1'b0)) u_m2 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_m2), .sdo_oe(oe_m2), .tx_data(tx_data), .tx_valid(tx_valid),
        .rx_data(rxd_m2), .rx_mode(mode_m2), .rx_valid(vld_m2), .rx_ready(rx_ready),
        .frame_err(ferr_m2), .overrun(ovr_m2), .err_clr(err_clr)
    );

    spi_sub_sync #(.CPOL(1'b1), .CPHA(1'b1)) u_m3 (
        .clk(clk), .rst_n(rst_n), .sclk(sclk1), .cs_n(cs_n), .sdi(sdi),
        .sdo(sdo_m3), .sdo_oe(oe_m3), .tx_data(tx_data), .tx_valid(tx_valid),
        .rx_data(rxd_m3), .rx_mode(mode_m3), .rx_valid(vld_m3), .rx_ready(rx_ready),
        .frame_err(ferr_m3), .overrun(ovr_m3), .err_clr(err_clr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk0 = 1'b0;
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
    endtask

    // driver tasks
    task automatic start_frame();
        cs_n = 1'b0;
        wait_clk(2 * Q);
    endtask

    task automatic end_frame();
        wait_clk(Q);
        cs_n = 1'b1;
        wait_clk(2 * Q);
    endtask

    // Each bit: sdi settles, leading edge, then trailing edge, so every mode
    // samples the same value. Captures the controller-side sdo view.
    task automatic send_bits(input logic [1:0] hdr, input logic [255:0] pay,
                             input int plen, input int nstop);
        int total;
        total = 2 + plen;
        cap0 = '0;
        cap1 = '0;
        vld_before_last = 1'bx;
        for (int i = 0; i < total; i++) begin
            if (i == nstop) break;
            sdi = (i < 2) ? hdr[1 - i] : pay[plen - 1 - (i - 2)];
            wait_clk(Q);
            cap0[i] = sdo_m0;
            sclk0 = 1'b1;
            wait_clk(2 * Q);
            cap1[i] = sdo;
            if (i == total - 1) vld_before_last = rx_valid;
            sclk0 = 1'b0;
            wait_clk(Q);
        end
    endtask

    task automatic pulse_ready();
        rx_ready = 1'b1;
        wait_clk(1);
        rx_ready = 1'b0;
        wait_clk(1);
    endtask

    task automatic pulse_clr();
        err_clr = 1'b1;
        wait_clk(1);
        err_clr = 1'b0;
        wait_clk(1);
    endtask

    // scenarios
    task automatic test_reset();
        do_reset();
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL reset_sdo: got %b exp 0", sdo); end
        checks++; if (sdo_oe !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b exp 0", sdo_oe); end
        checks++; if (rx_data !== 256'd0) begin errors++; $display("FAIL reset_rx_data: got %h exp 0", rx_data); end
        checks++; if (rx_mode !== 2'b00) begin errors++; $display("FAIL reset_rx_mode: got %b exp 00", rx_mode); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid: got %b exp 0", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err: got %b exp 0", frame_err); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b exp 0", overrun); end
    endtask

    task automatic test_basic_128();
        tx_data  = TXA5;
        tx_valid = 1'b1;
        start_frame();
        checks++; if (sdo_oe !== 1'b1) begin errors++; $display("FAIL basic_oe: got %b exp 1", sdo_oe); end
        send_bits(2'b00, {128'd0, P128}, 128, 999);
        checks++; if (vld_before_last !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b exp 0", vld_before_last); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b exp 1", rx_valid); end
        checks++; if (rx_data !== {128'd0, P128}) begin errors++; $display("FAIL basic_rx_data: got %h exp %h", rx_data, {128'd0, P128}); end
        checks++; if (rx_mode !== 2'b00) begin errors++; $display("FAIL basic_rx_mode: got %b exp 00", rx_mode); end
        for (int i = 0; i < 128; i++) got[127 - i] = cap1[i];
        checks++; if (got !== TXA5) begin errors++; $display("FAIL basic_sdo_stream: got %h exp %h", got, TXA5); end
        checks++; if (cap1[129:128] !== 2'b00) begin errors++; $display("FAIL basic_sdo_tail: got %b exp 00", cap1[129:128]); end
        end_frame();
        checks++; if (sdo_oe !== 1'b0) begin errors++; $display("FAIL basic_oe_off: got %b exp 0", sdo_oe); end
        pulse_ready();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL basic_accept: got %b exp 0", rx_valid); end
    endtask

    task automatic test_overrun();
        tx_valid = 1'b0;
        start_frame();
        send_bits(2'b10, {256{1'b1}}, 256, 999);
        end_frame();
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_first_valid: got %b exp 1", rx_valid); end
        checks++; if (rx_data !== {256{1'b1}}) begin errors++; $display("FAIL ovr_first_data: got %h exp all ones", rx_data); end
        checks++; if (rx_mode !== 2'b10) begin errors++; $display("FAIL ovr_first_mode: got %b exp 10", rx_mode); end
        checks++; if (cap1[257:0] !== 258'd0) begin errors++; $display("FAIL ovr_sdo_zero: got %h exp 0", cap1[257:0]); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_not_yet: got %b exp 0", overrun); end
        start_frame();
        send_bits(2'b10, {32{8'h55}}, 256, 999);
        end_frame();
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_set: got %b exp 1", overrun); end
        checks++; if (rx_data !== {256{1'b1}}) begin errors++; $display("FAIL ovr_data_held: got %h exp all ones", rx_data); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_valid_held: got %b exp 1", rx_valid); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL ovr_no_ferr: got %b exp 0", frame_err); end
        pulse_clr();
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b exp 0", overrun); end
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL ovr_clr_keeps_valid: got %b exp 1", rx_valid); end
        pulse_ready();
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL ovr_accept: got %b exp 0", rx_valid); end
    endtask

    task automatic test_rsvd_hdr();
        tx_data  = TXA5;
        tx_valid = 1'b1;
        start_frame();
        send_bits(2'b11, {128'd0, P128}, 128, 999);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL rsvd_ferr: got %b exp 1", frame_err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rsvd_no_valid: got %b exp 0", rx_valid); end
        checks++; if (cap1[1:0] !== 2'b01) begin errors++; $display("FAIL rsvd_sdo_head: got %b exp 01", cap1[1:0]); end
        checks++; if (cap1[129:2] !== 128'd0) begin errors++; $display("FAIL rsvd_sdo_quiet: got %h exp 0", cap1[129:2]); end
        end_frame();
        pulse_clr();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rsvd_clear: got %b exp 0", frame_err); end
        start_frame();
        send_bits(2'b01, {64'd0, P192}, 192, 999);
        end_frame();
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL k192_valid: got %b exp 1", rx_valid); end
        checks++; if (rx_mode !== 2'b01) begin errors++; $display("FAIL k192_mode: got %b exp 01", rx_mode); end
        checks++; if (rx_data !== {64'd0, P192}) begin errors++; $display("FAIL k192_data: got %h exp %h", rx_data, {64'd0, P192}); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL k192_no_ferr: got %b exp 0", frame_err); end
        pulse_ready();
    endtask

    task automatic test_early_deassert();
        held = {64'd0, P192};
        start_frame();
        send_bits(2'b01, {64'd0, P192}, 192, 100);
        checks++; if (sdo_oe !== 1'b1) begin errors++; $display("FAIL early_oe_on: got %b exp 1", sdo_oe); end
        cs_n = 1'b1;
        wait_clk(3);
        checks++; if (sdo_oe !== 1'b0) begin errors++; $display("FAIL early_oe_off: got %b exp 0", sdo_oe); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL early_sdo: got %b exp 0", sdo); end
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL early_ferr: got %b exp 1", frame_err); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL early_no_valid: got %b exp 0", rx_valid); end
        checks++; if (rx_data !== held) begin errors++; $display("FAIL early_data_kept: got %h exp %h", rx_data, held); end
        wait_clk(4);
    endtask

    task automatic test_reset_mid();
        tx_data  = TXA5;
        tx_valid = 1'b1;
        start_frame();
        send_bits(2'b00, {128'd0, P128}, 128, 62);
        checks++; if (sdo_oe !== 1'b1) begin errors++; $display("FAIL rstmid_pre_oe: got %b exp 1", sdo_oe); end
        rst_n = 1'b0;
        cs_n  = 1'b1;
        sclk0 = 1'b0;
        #1;
        checks++; if ({sdo, sdo_oe, rx_valid, frame_err, overrun} !== 5'b0) begin
            errors++; $display("FAIL rstmid_flags: got %b exp 00000", {sdo, sdo_oe, rx_valid, frame_err, overrun});
        end
        checks++; if ({rx_data, rx_mode} !== 258'd0) begin errors++; $display("FAIL rstmid_data: got %h exp 0", {rx_data, rx_mode}); end
        wait_clk(3);
        rst_n = 1'b1;
        wait_clk(4);
        start_frame();
        send_bits(2'b00, {128'd0, PDEAD}, 128, 999);
        end_frame();
        checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL rstmid_valid: got %b exp 1", rx_valid); end
        checks++; if (rx_data !== {128'd0, PDEAD}) begin errors++; $display("FAIL rstmid_rx_data: got %h exp %h", rx_data, {128'd0, PDEAD}); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL rstmid_ferr: got %b exp 0", frame_err); end
        pulse_ready();
    endtask

    task automatic test_modes();
        do_reset();
        tx_data  = TXC3;
        tx_valid = 1'b1;
        start_frame();
        checks++; if (sdo_m0 !== 1'b1) begin errors++; $display("FAIL m0_msb_early: got %b exp 1", sdo_m0); end
        checks++; if (sdo_m2 !== 1'b1) begin errors++; $display("FAIL m2_msb_early: got %b exp 1", sdo_m2); end
        checks++; if (sdo !== 1'b0) begin errors++; $display("FAIL m1_sdo_idle: got %b exp 0", sdo); end
        send_bits(2'b00, {128'd0, PDEAD}, 128, 999);
        end_frame();
        checks++; if (rx_data !== {128'd0, PDEAD}) begin errors++; $display("FAIL m1_data: got %h exp %h", rx_data, {128'd0, PDEAD}); end
        checks++; if (rxd_m0 !== {128'd0, PDEAD}) begin errors++; $display("FAIL m0_data: got %h exp %h", rxd_m0, {128'd0, PDEAD}); end
        checks++; if (rxd_m2 !== {128'd0, PDEAD}) begin errors++; $display("FAIL m2_data: got %h exp %h", rxd_m2, {128'd0, PDEAD}); end
        checks++; if (rxd_m3 !== {128'd0, PDEAD}) begin errors++; $display("FAIL m3_data: got %h exp %h", rxd_m3, {128'd0, PDEAD}); end
        checks++; if ({rx_valid, vld_m0, vld_m2, vld_m3} !== 4'b1111) begin
            errors++; $display("FAIL modes_valid: got %b exp 1111", {rx_valid, vld_m0, vld_m2, vld_m3});
        end
        checks++; if ({mode_m0, mode_m2, mode_m3} !== 6'b0) begin errors++; $display("FAIL modes_mode: got %b exp 0", {mode_m0, mode_m2, mode_m3}); end
        for (int i = 0; i < 128; i++) got[127 - i] = cap0[i];
        checks++; if (got !== TXC3) begin errors++; $display("FAIL m0_sdo_stream: got %h exp %h", got, TXC3); end
        for (int i = 0; i < 128; i++) got[127 - i] = cap1[i];
        checks++; if (got !== TXC3) begin errors++; $display("FAIL m1_sdo_stream: got %h exp %h", got, TXC3); end
        pulse_ready();
        checks++; if ({rx_valid, vld_m0, vld_m2, vld_m3} !== 4'b0000) begin
            errors++; $display("FAIL modes_accept: got %b exp 0000", {rx_valid, vld_m0, vld_m2, vld_m3});
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        rst_n    = 1'b1;
        cs_n     = 1'b1;
        sclk0    = 1'b0;
        sdi      = 1'b0;
        tx_data  = '0;
        tx_valid = 1'b0;
        rx_ready = 1'b0;
        err_clr  = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_128();
        test_overrun();
        test_rsvd_hdr();
        test_early_deassert();
        test_reset_mid();
        test_modes();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
